// File: rtl/exe_stage_if.sv
// Purpose: groups the EXE stage operand, forwarding, control and result signals.
// Latency: none, wiring only.
// Backpressure: stall is carried back to the pipeline that drives this bundle.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

interface exe_stage_if;
   // from the ID/EXE register
   logic [`EXE_CMD_LEN-1:0]       EXE_CMD;
   logic [`WORD_LEN-1:0]          val1;
   logic [`WORD_LEN-1:0]          val2;
   logic [`WORD_LEN-1:0]          ST_value;
   logic [`REG_FILE_ADDR_LEN-1:0] src1;
   logic [`REG_FILE_ADDR_LEN-1:0] src2;
   logic [`REG_FILE_ADDR_LEN-1:0] dest;
   logic                          is_imm;
   logic                          WB_EN;
   logic                          MEM_R_EN;
   logic                          MEM_W_EN;
   // forwarding sources from the later stages
   logic                          mem_wb_en;
   logic                          wb_wb_en;
   logic [`REG_FILE_ADDR_LEN-1:0] mem_dest;
   logic [`REG_FILE_ADDR_LEN-1:0] wb_dest;
   logic [`WORD_LEN-1:0]          mem_value;
   logic [`WORD_LEN-1:0]          wb_value;
   // towards the EXE/MEM register and hazard logic
   logic [`WORD_LEN-1:0]          alu_result;
   logic [`WORD_LEN-1:0]          st_value_out;
   logic [`REG_FILE_ADDR_LEN-1:0] dest_out;
   logic                          WB_EN_out;
   logic                          MEM_R_EN_out;
   logic                          MEM_W_EN_out;
   logic                          stall;

   modport slave (
      input  EXE_CMD, val1, val2, ST_value, src1, src2, dest, is_imm,
             WB_EN, MEM_R_EN, MEM_W_EN, mem_wb_en, wb_wb_en, mem_dest,
             wb_dest, mem_value, wb_value,
      output alu_result, st_value_out, dest_out, WB_EN_out, MEM_R_EN_out,
             MEM_W_EN_out, stall
   );

   modport master (
      output EXE_CMD, val1, val2, ST_value, src1, src2, dest, is_imm,
             WB_EN, MEM_R_EN, MEM_W_EN, mem_wb_en, wb_wb_en, mem_dest,
             wb_dest, mem_value, wb_value,
      input  alu_result, st_value_out, dest_out, WB_EN_out, MEM_R_EN_out,
             MEM_W_EN_out, stall
   );
endinterface

// File: rtl/exe_stage.sv
// Purpose: EXE stage - operand forwarding, ALU, optional iterative multiplier (macro ITER_MUL_EN).
// Latency: non-MUL ops combinational; MUL holds stall for 33 cycles, result in the 34th.
// Backpressure: stall freezes PC, IF/ID and ID/EXE and turns the outgoing control bits into a bubble.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

module exe_stage (
   input logic        clk,
   input logic        rst,
   exe_stage_if.slave io_exe
);
   localparam logic [`EXE_CMD_LEN-1:0] CMD_ADD = 4'b0000;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_SUB = 4'b0010;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_AND = 4'b0100;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_OR  = 4'b0101;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_NOR = 4'b0110;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_XOR = 4'b0111;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_SLL = 4'b1000;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_SRL = 4'b1001;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_SRA = 4'b1010;
   localparam logic [`EXE_CMD_LEN-1:0] CMD_MUL = 4'b1100;

   logic                 w_src1_mem, w_src1_wb, w_src2_mem, w_src2_wb;
   logic [`WORD_LEN-1:0] w_op1, w_op2, w_st;
   logic [4:0]           w_shamt;
   logic [`WORD_LEN-1:0] w_alu;
   logic [`WORD_LEN-1:0] w_mul_result;
   logic                 w_stall;
   logic                 w_is_mul;

   // Register 0 is hard-wired, so a match on index 0 never forwards.
   assign w_src1_mem = io_exe.mem_wb_en && (io_exe.mem_dest == io_exe.src1) && (io_exe.src1 != '0);
   assign w_src1_wb  = io_exe.wb_wb_en  && (io_exe.wb_dest  == io_exe.src1) && (io_exe.src1 != '0);
   assign w_src2_mem = io_exe.mem_wb_en && (io_exe.mem_dest == io_exe.src2) && (io_exe.src2 != '0);
   assign w_src2_wb  = io_exe.wb_wb_en  && (io_exe.wb_dest  == io_exe.src2) && (io_exe.src2 != '0);
   assign w_is_mul   = (io_exe.EXE_CMD == CMD_MUL);

   // Forwarding muxes: MEM is the younger producer and wins over WB; immediates bypass forwarding.
   always_comb begin
      w_op1 = io_exe.val1;
      w_op2 = io_exe.val2;
      w_st  = io_exe.ST_value;
      if (w_src1_mem)     w_op1 = io_exe.mem_value;
      else if (w_src1_wb) w_op1 = io_exe.wb_value;
      if (w_src2_mem)     w_st  = io_exe.mem_value;
      else if (w_src2_wb) w_st  = io_exe.wb_value;
      if (!io_exe.is_imm) begin
         if (w_src2_mem)     w_op2 = io_exe.mem_value;
         else if (w_src2_wb) w_op2 = io_exe.wb_value;
      end
   end

   assign w_shamt = w_op2[4:0];

`ifdef ITER_MUL_EN
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t               r_state;
   logic [4:0]           r_cnt;
   logic [`WORD_LEN-1:0] r_acc;
   logic [`WORD_LEN-1:0] r_op1;
   logic [`WORD_LEN-1:0] r_op2;
   logic [`WORD_LEN-1:0] w_addend;

   // Partial product for the current bit; only the low word of the product is ever needed.
   assign w_addend = r_op2[r_cnt] ? (r_op1 << r_cnt) : '0;

   // Shift-add multiplier: capture operands once, then 32 accumulate steps, then one result cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_op1   <= '0;
         r_op2   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_is_mul) begin
                  r_op1   <= w_op1;
                  r_op2   <= w_op2;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_acc <= r_acc + w_addend;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Stall rises in the issuing cycle itself so the front end freezes before the next edge.
   assign w_stall      = !rst && ((r_state == ST_IDLE && w_is_mul) || (r_state == ST_BUSY));
   assign w_mul_result = (r_state == ST_DONE) ? r_acc : '0;
`else
   logic w_unused_clk_rst;

   assign w_unused_clk_rst = clk ^ rst;
   assign w_stall          = 1'b0;
   assign w_mul_result     = '0;
`endif

   // Single-cycle ALU; MUL only shows the multiplier result, everything undefined reads as 0.
   always_comb begin
      w_alu = '0;
      case (io_exe.EXE_CMD)
         CMD_ADD: w_alu = w_op1 + w_op2;
         CMD_SUB: w_alu = w_op1 - w_op2;
         CMD_AND: w_alu = w_op1 & w_op2;
         CMD_OR:  w_alu = w_op1 | w_op2;
         CMD_NOR: w_alu = ~(w_op1 | w_op2);
         CMD_XOR: w_alu = w_op1 ^ w_op2;
         CMD_SLL: w_alu = w_op1 << w_shamt;
         CMD_SRL: w_alu = w_op1 >> w_shamt;
         CMD_SRA: w_alu = `WORD_LEN'($signed(w_op1) >>> w_shamt);
         CMD_MUL: w_alu = w_mul_result;
         default: w_alu = '0;
      endcase
   end

   assign io_exe.alu_result   = w_alu;
   assign io_exe.st_value_out = w_st;
   assign io_exe.dest_out     = io_exe.dest;
   assign io_exe.stall        = w_stall;
   assign io_exe.WB_EN_out    = io_exe.WB_EN    && !w_stall;
   assign io_exe.MEM_R_EN_out = io_exe.MEM_R_EN && !w_stall;
   assign io_exe.MEM_W_EN_out = io_exe.MEM_W_EN && !w_stall;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vectors, expectations queued by the driver and
// checked by an independent monitor on the falling edge.
// Build with ITER_MUL_EN defined to exercise the multiplier sequences.
module tb_exe_stage;
   localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0010, C_AND = 4'b0100, C_OR  = 4'b0101;
   localparam logic [3:0] C_NOR = 4'b0110, C_XOR = 4'b0111, C_SLL = 4'b1000, C_SRL = 4'b1001;
   localparam logic [3:0] C_SRA = 4'b1010, C_MUL = 4'b1100, C_NOP = 4'b1111, C_UND = 4'b0011;

   typedef struct {
      string       nm;
      logic        chk_alu;
      logic [31:0] alu;
      logic [31:0] st;
      logic [4:0]  dest;
      logic [2:0]  ctrl;
      logic        stall;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_vld = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;
   exp_t q[$];
   exp_t m_e;

   exe_stage_if u_if ();

   exe_stage u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_exe (u_if.slave)
   );

   always #5 clk = ~clk;

   // Monitor: pop one expectation for every presented cycle and compare.
   always @(negedge clk) begin
      if (tb_vld) begin
         n_run++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL no_expectation: output presented but scoreboard empty");
         end else begin
            m_e = q.pop_front();
            if ((m_e.chk_alu && u_if.alu_result !== m_e.alu) ||
                u_if.st_value_out !== m_e.st || u_if.dest_out !== m_e.dest ||
                {u_if.WB_EN_out, u_if.MEM_R_EN_out, u_if.MEM_W_EN_out} !== m_e.ctrl ||
                u_if.stall !== m_e.stall) begin
               n_fail++;
               $display("FAIL %s: got alu=%h st=%h dest=%0d ctrl=%b stall=%b, want alu=%h(chk=%b) st=%h dest=%0d ctrl=%b stall=%b",
                        m_e.nm, u_if.alu_result, u_if.st_value_out, u_if.dest_out,
                        {u_if.WB_EN_out, u_if.MEM_R_EN_out, u_if.MEM_W_EN_out}, u_if.stall,
                        m_e.alu, m_e.chk_alu, m_e.st, m_e.dest, m_e.ctrl, m_e.stall);
            end
         end
      end
   end

   task automatic set_op(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] stv, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic imm, input logic [2:0] ctl);
      u_if.EXE_CMD  = cmd;
      u_if.val1     = v1;
      u_if.val2     = v2;
      u_if.ST_value = stv;
      u_if.src1     = s1;
      u_if.src2     = s2;
      u_if.dest     = d;
      u_if.is_imm   = imm;
      {u_if.WB_EN, u_if.MEM_R_EN, u_if.MEM_W_EN} = ctl;
   endtask

   task automatic set_hz(input logic mwe, input logic [4:0] md, input logic [31:0] mv,
                         input logic wwe, input logic [4:0] wd, input logic [31:0] wv);
      u_if.mem_wb_en = mwe;
      u_if.mem_dest  = md;
      u_if.mem_value = mv;
      u_if.wb_wb_en  = wwe;
      u_if.wb_dest   = wd;
      u_if.wb_value  = wv;
   endtask

   // Queue the expectation for the current cycle, then advance to just after the next edge.
   task automatic chk(input string nm, input logic ca, input logic [31:0] a, input logic [31:0] stx,
                      input logic [2:0] ctl, input logic stl);
      exp_t e;
      e.nm      = nm;
      e.chk_alu = ca;
      e.alu     = a;
      e.st      = stx;
      e.dest    = u_if.dest;
      e.ctrl    = ctl;
      e.stall   = stl;
      q.push_back(e);
      tb_vld = 1'b1;
      @(posedge clk);
      #1;
      tb_vld = 1'b0;
   endtask

`ifdef ITER_MUL_EN
   // One full multiply: issue cycle, 32 busy cycles, one result cycle.
   // With disturb set, forwarding sources for both operands change while busy.
   task automatic mul_seq(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic disturb);
      logic [31:0] st_exp;
      st_exp = 32'h0;
      set_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_op(C_MUL, a, b, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b100);
      chk({nm, "_issue"}, 1'b0, 32'h0, st_exp, 3'b000, 1'b1);
      for (int i = 0; i < 32; i++) begin
         if (disturb) begin
            set_hz(1'b1, 5'd1, 32'h1234, 1'b1, 5'd2, 32'h55);
            st_exp = 32'h55;
         end
         chk({nm, "_busy"}, 1'b0, 32'h0, st_exp, 3'b000, 1'b1);
      end
      chk({nm, "_done"}, 1'b1, r, st_exp, 3'b100, 1'b0);
      set_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask
`endif

   initial begin
      set_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_op(C_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000);
      @(posedge clk);
      #1;
      // stall must stay low under reset even with MUL presented
      set_op(C_MUL, 32'd6, 32'd7, 32'h0, 5'd0, 5'd0, 5'd1, 1'b0, 3'b100);
      chk("rst_mul_nostall", 1'b1, 32'h0, 32'h0, 3'b100, 1'b0);
      rst = 1'b0;
      set_op(C_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b0, 3'b100);
      chk("reset_idle_nop", 1'b1, 32'h0, 32'h0, 3'b100, 1'b0);

      set_op(C_ADD, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b101);
      chk("add_5_7", 1'b1, 32'd12, 32'h0, 3'b101, 1'b0);

      set_hz(1'b1, 5'd3, 32'd20, 1'b1, 5'd3, 32'd99);
      set_op(C_SUB, 32'd1000, 32'd4, 32'h0, 5'd3, 5'd5, 5'd4, 1'b0, 3'b100);
      chk("sub_mem_wins", 1'b1, 32'd16, 32'h0, 3'b100, 1'b0);

      set_hz(1'b1, 5'd0, 32'd20, 1'b1, 5'd0, 32'd99);
      set_op(C_SUB, 32'd50, 32'd4, 32'h0, 5'd0, 5'd5, 5'd4, 1'b0, 3'b100);
      chk("sub_src_zero", 1'b1, 32'd46, 32'h0, 3'b100, 1'b0);

      set_hz(1'b0, 5'd4, 32'd7, 1'b1, 5'd4, 32'd100);
      set_op(C_ADD, 32'd1, 32'd1, 32'h0, 5'd4, 5'd5, 5'd6, 1'b0, 3'b010);
      chk("add_wb_fwd", 1'b1, 32'd101, 32'h0, 3'b010, 1'b0);

      set_hz(1'b1, 5'd6, 32'd1000, 1'b0, 5'd0, 32'h0);
      set_op(C_ADD, 32'd5, 32'd10, 32'd77, 5'd1, 5'd6, 5'd7, 1'b1, 3'b001);
      chk("imm_no_fwd_st_fwd", 1'b1, 32'd15, 32'd1000, 3'b001, 1'b0);
      set_op(C_ADD, 32'd5, 32'd10, 32'd77, 5'd1, 5'd6, 5'd7, 1'b0, 3'b001);
      chk("reg_op2_fwd", 1'b1, 32'd1005, 32'd1000, 3'b001, 1'b0);

      set_hz(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      set_op(C_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b100);
      chk("and", 1'b1, 32'h00F0_000F, 32'h0, 3'b100, 1'b0);
      set_op(C_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b100);
      chk("or", 1'b1, 32'hFFF0_0FFF, 32'h0, 3'b100, 1'b0);
      set_op(C_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b100);
      chk("nor", 1'b1, 32'h000F_F000, 32'h0, 3'b100, 1'b0);
      set_op(C_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b100);
      chk("xor", 1'b1, 32'hFF00_0FF0, 32'h0, 3'b100, 1'b0);
      set_op(C_SLL, 32'h1, 32'h24, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 3'b100);
      chk("sll_low5", 1'b1, 32'h10, 32'h0, 3'b100, 1'b0);
      set_op(C_SRL, 32'h8000_0000, 32'h3F, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 3'b100);
      chk("srl_31", 1'b1, 32'h1, 32'h0, 3'b100, 1'b0);
      set_op(C_SRA, 32'h8000_0000, 32'h4, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 3'b100);
      chk("sra_signfill", 1'b1, 32'hF800_0000, 32'h0, 3'b100, 1'b0);
      set_op(C_ADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 3'b100);
      chk("add_wrap", 1'b1, 32'h1, 32'h0, 3'b100, 1'b0);
      set_op(C_SUB, 32'h0, 32'h1, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 3'b100);
      chk("sub_wrap", 1'b1, 32'hFFFF_FFFF, 32'h0, 3'b100, 1'b0);
      set_op(C_NOP, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b111);
      chk("nop_zero", 1'b1, 32'h0, 32'h0, 3'b111, 1'b0);
      set_op(C_UND, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd8, 1'b0, 3'b011);
      chk("undef_zero", 1'b1, 32'h0, 32'h0, 3'b011, 1'b0);

`ifdef ITER_MUL_EN
      mul_seq("mul_ffff_3", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b1);
      mul_seq("mul_6_7", 32'd6, 32'd7, 32'd42, 1'b0);
      mul_seq("mul_2_8", 32'd2, 32'd8, 32'd16, 1'b0);
      // abandon a multiply with reset in its tenth busy cycle
      set_op(C_MUL, 32'd3, 32'd5, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b100);
      chk("mul_abort_issue", 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      for (int i = 0; i < 9; i++) chk("mul_abort_busy", 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
      rst = 1'b1;
      chk("mul_abort_rst", 1'b1, 32'h0, 32'h0, 3'b100, 1'b0);
      rst = 1'b0;
      set_op(C_NOP, 32'd3, 32'd5, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b100);
      chk("mul_abort_idle", 1'b1, 32'h0, 32'h0, 3'b100, 1'b0);
      mul_seq("mul_3_3", 32'd3, 32'd3, 32'd9, 1'b0);
`else
      set_op(C_MUL, 32'd6, 32'd7, 32'h0, 5'd1, 5'd2, 5'd9, 1'b0, 3'b100);
      for (int i = 0; i < 40; i++) chk("mul_disabled", 1'b1, 32'h0, 32'h0, 3'b100, 1'b0);
`endif

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
